conware_gen: RTL and testbench

CONWARE_GEN -- requirements
Module: conware_gen

---
 rtl/conware_pkg.sv | 18 +
 rtl/conway_rule_cell.sv | 26 ++
 rtl/conware_gen.sv | 166 ++++++++++++++++
 tb/tb_conware_gen.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conware_pkg.sv
// Shared types and constants for the Game-of-Life frame generator.
// FSM encoding, default B3/S23 rule masks and the generation-counter width.
package conware_pkg;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_SEND    = 2'd2
  } state_t;

  localparam logic [8:0] DEF_BIRTH_MASK   = 9'b000001000;
  localparam logic [8:0] DEF_SURVIVE_MASK = 9'b000001100;

  localparam int GEN_W      = 8;
  localparam int NBHD_W     = 9;
  localparam int CENTER_BIT = 4;

endpackage

// File: rtl/conway_rule_cell.sv
// Combinational life rule for one cell: 3x3 neighbourhood (centre at bit 4)
// plus birth/survive masks -> next state of the centre cell.
module conway_rule_cell
  import conware_pkg::*;
(
  input  logic [NBHD_W-1:0] i_nbhd,
  input  logic [8:0]        i_birth_mask,
  input  logic [8:0]        i_survive_mask,
  output logic              o_alive
);

  logic [3:0] w_count;

  always_comb begin
    // NOTE: assigning a default before the loop keeps this block purely
    // combinational; a path that leaves w_count unwritten would infer a latch.
    w_count = '0;
    for (int i = 0; i < NBHD_W; i++) begin
      if (i != CENTER_BIT) w_count = w_count + {3'b000, i_nbhd[i]};
    end
  end

  assign o_alive = i_nbhd[CENTER_BIT] ? i_survive_mask[w_count]
                                      : i_birth_mask[w_count];

endmodule

// File: rtl/conware_gen.sv
// Streams a binary life frame in, runs gen_count generations one row per
// cycle between two ping-pong banks, and streams the result out as colours.
module conware_gen
  import conware_pkg::*;
#(
  parameter int unsigned DWIDTH       = 32,
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned HEIGHT       = 32,
  parameter logic [8:0]  BIRTH_MASK   = DEF_BIRTH_MASK,
  parameter logic [8:0]  SURVIVE_MASK = DEF_SURVIVE_MASK
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] alive_color,
  input  logic [DWIDTH-1:0] dead_color,
  input  logic [GEN_W-1:0]  gen_count,
  input  logic              wrap,
  input  logic              S_AXIS_TVALID,
  output logic              S_AXIS_TREADY,
  input  logic [DWIDTH-1:0] S_AXIS_TDATA,
  input  logic              S_AXIS_TLAST,
  output logic              M_AXIS_TVALID,
  input  logic              M_AXIS_TREADY,
  output logic [DWIDTH-1:0] M_AXIS_TDATA,
  output logic              M_AXIS_TLAST,
  output logic              err_tlast
);

  localparam int COL_W = $clog2(WIDTH);
  localparam int ROW_W = $clog2(HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(HEIGHT - 1);
  localparam logic [ROW_W-1:0] ROW_FIRST = '0;
  localparam logic [GEN_W-1:0] GEN_ONE   = GEN_W'(1);

  state_t                  r_state, w_state_next;
  logic [ROW_W-1:0]        r_row;
  logic [COL_W-1:0]        r_col;
  logic [GEN_W-1:0]        r_gen;
  logic                    r_wrap;
  logic                    r_sel;
  logic                    r_out_en;
  logic                    r_err;
  logic [HEIGHT-1:0][WIDTH-1:0] r_bank [2];

  logic w_s_hs, w_m_hs, w_first_beat, w_last_cell, w_load_done;
  logic w_restart, w_adv;
  logic [GEN_W-1:0] w_gen_eff;
  logic [WIDTH-1:0] w_up, w_mid, w_dn, w_next_row;
  logic [WIDTH+1:0] w_up_x, w_mid_x, w_dn_x;

  assign S_AXIS_TREADY = (r_state == ST_LOAD) && r_out_en;
  assign M_AXIS_TVALID = (r_state == ST_SEND);
  assign M_AXIS_TLAST  = M_AXIS_TVALID && w_last_cell;
  assign M_AXIS_TDATA  = (M_AXIS_TVALID && r_bank[r_sel][r_row][r_col]) ? alive_color
                                                                        : dead_color;
  assign err_tlast     = r_err;

  assign w_s_hs       = S_AXIS_TREADY && S_AXIS_TVALID;
  assign w_m_hs       = M_AXIS_TVALID && M_AXIS_TREADY;
  assign w_first_beat = (r_row == ROW_FIRST) && (r_col == '0);
  assign w_last_cell  = (r_row == ROW_LAST) && (r_col == COL_LAST);
  assign w_load_done  = w_s_hs && (w_last_cell || S_AXIS_TLAST);
  assign w_gen_eff    = w_first_beat ? gen_count : r_gen;
  assign w_restart    = w_load_done || (w_m_hs && w_last_cell);
  assign w_adv        = w_s_hs || w_m_hs;

  // Rows above/below the one being updated; off-grid rows read as dead unless wrapping.
  always_comb begin
    w_mid = r_bank[r_sel][r_row];
    w_up  = '0;
    w_dn  = '0;
    if (r_row != ROW_FIRST) w_up = r_bank[r_sel][r_row - 1'b1];
    else if (r_wrap)        w_up = r_bank[r_sel][ROW_LAST];
    if (r_row != ROW_LAST)  w_dn = r_bank[r_sel][r_row + 1'b1];
    else if (r_wrap)        w_dn = r_bank[r_sel][ROW_FIRST];
  end

  function automatic logic [WIDTH+1:0] pad_row(input logic [WIDTH-1:0] row,
                                               input logic            wrap_en);
    return {wrap_en & row[0], row, wrap_en & row[WIDTH-1]};
  endfunction

  assign w_up_x  = pad_row(w_up,  r_wrap);
  assign w_mid_x = pad_row(w_mid, r_wrap);
  assign w_dn_x  = pad_row(w_dn,  r_wrap);

  for (genvar c = 0; c < WIDTH; c++) begin : g_cell
    conway_rule_cell u_cell (
      .i_nbhd         ({w_up_x[c +: 3], w_mid_x[c +: 3], w_dn_x[c +: 3]}),
      .i_birth_mask   (BIRTH_MASK),
      .i_survive_mask (SURVIVE_MASK),
      .o_alive        (w_next_row[c])
    );
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_LOAD:    if (w_load_done) w_state_next = (w_gen_eff == '0) ? ST_SEND : ST_COMPUTE;
      ST_COMPUTE: if ((r_row == ROW_LAST) && (r_gen == GEN_ONE)) w_state_next = ST_SEND;
      ST_SEND:    if (w_m_hs && w_last_cell) w_state_next = ST_LOAD;
      default:    w_state_next = ST_LOAD;
    endcase
  end

  // NOTE: every register here uses <= so all updates see pre-edge values;
  // blocking assignments would make the result depend on statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= ST_LOAD;
      r_row    <= '0;
      r_col    <= '0;
      r_gen    <= '0;
      r_wrap   <= 1'b0;
      r_sel    <= 1'b0;
      r_out_en <= 1'b0;
      r_err    <= 1'b0;
      // NOTE: the banks are flops, not RAM, and must start dead because an
      // early-TLAST frame relies on unwritten cells reading as zero.
      r_bank   <= '{default: '0};
    end else begin
      r_state  <= w_state_next;
      r_out_en <= 1'b1;
      r_err    <= 1'b0;

      if (w_restart) begin
        r_row <= '0;
        r_col <= '0;
      end else if (w_adv) begin
        if (r_col == COL_LAST) begin
          r_col <= '0;
          r_row <= r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end else if (r_state == ST_COMPUTE) begin
        r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
      end

      case (r_state)
        ST_LOAD: if (w_s_hs) begin
          r_bank[r_sel][r_row][r_col] <= (S_AXIS_TDATA == alive_color);
          if (w_first_beat) begin
            r_gen  <= gen_count;
            r_wrap <= wrap;
          end
          if (w_load_done) r_err <= w_last_cell ? !S_AXIS_TLAST : 1'b1;
        end
        ST_COMPUTE: begin
          r_bank[~r_sel][r_row] <= w_next_row;
          if (r_row == ROW_LAST) begin
            r_sel <= ~r_sel;
            r_gen <= r_gen - 1'b1;
          end
        end
        ST_SEND: if (w_m_hs && w_last_cell) begin
          r_sel  <= 1'b0;
          r_bank <= '{default: '0};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conware_gen.sv
// Directed bench for conware_gen on a 4x4 grid; a B3/S23 and a B36/S23
// instance run in lock-step against an independent life model via scoreboards.
module tb_conware_gen;

  localparam int          W = 4;
  localparam int          H = 4;
  localparam int          N = W * H;
  localparam logic [31:0] ALIVE = 32'hFFFF_FFFF;
  localparam logic [31:0] DEAD  = 32'h0000_0000;
  localparam logic [8:0]  B3    = 9'b000001000;
  localparam logic [8:0]  B36   = 9'b001001000;
  localparam logic [8:0]  S23   = 9'b000001100;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alive_color, dead_color;
  logic [7:0]  gen_count;
  logic        wrap;
  logic        s_tvalid, s_tlast;
  logic [31:0] s_tdata;
  logic        m_tready;
  logic        s_tready, m_tvalid, m_tlast, err_tlast;
  logic [31:0] m_tdata;
  logic        s_tready_b, m_tvalid_b, m_tlast_b, err_tlast_b;
  logic [31:0] m_tdata_b;

  beat_t q_exp[$];
  beat_t q_exp_b[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    err_seen = 0;
  int    err_seen_b = 0;

  always #5 clk = ~clk;

  conware_gen #(.DWIDTH(32), .WIDTH(W), .HEIGHT(H)) u_dut (
    .clk(clk), .rst(rst), .alive_color(alive_color), .dead_color(dead_color),
    .gen_count(gen_count), .wrap(wrap),
    .S_AXIS_TVALID(s_tvalid), .S_AXIS_TREADY(s_tready), .S_AXIS_TDATA(s_tdata),
    .S_AXIS_TLAST(s_tlast),
    .M_AXIS_TVALID(m_tvalid), .M_AXIS_TREADY(m_tready), .M_AXIS_TDATA(m_tdata),
    .M_AXIS_TLAST(m_tlast), .err_tlast(err_tlast)
  );

  conware_gen #(.DWIDTH(32), .WIDTH(W), .HEIGHT(H), .BIRTH_MASK(B36)) u_dut_b36 (
    .clk(clk), .rst(rst), .alive_color(alive_color), .dead_color(dead_color),
    .gen_count(gen_count), .wrap(wrap),
    .S_AXIS_TVALID(s_tvalid), .S_AXIS_TREADY(s_tready_b), .S_AXIS_TDATA(s_tdata),
    .S_AXIS_TLAST(s_tlast),
    .M_AXIS_TVALID(m_tvalid_b), .M_AXIS_TREADY(m_tready), .M_AXIS_TDATA(m_tdata_b),
    .M_AXIS_TLAST(m_tlast_b), .err_tlast(err_tlast_b)
  );

  // Counting high cycles (not edges) also catches a pulse that is too long.
  always @(negedge clk) begin
    if (err_tlast === 1'b1)   err_seen++;
    if (err_tlast_b === 1'b1) err_seen_b++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] life_step(input logic [N-1:0] g, input logic w,
                                             input logic [8:0] bm, input logic [8:0] sm);
    logic [N-1:0] nx;
    nx = '0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        int n;
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            int rr, cc;
            rr = r + dr;
            cc = c + dc;
            if (dr == 0 && dc == 0) continue;
            if (w) begin
              rr = (rr + H) % H;
              cc = (cc + W) % W;
            end else if (rr < 0 || rr >= H || cc < 0 || cc >= W) begin
              continue;
            end
            n += int'(g[rr*W + cc]);
          end
        end
        nx[r*W + c] = g[r*W + c] ? sm[n] : bm[n];
      end
    end
    return nx;
  endfunction

  // tlast_beat < 0 means TLAST is never raised; n_out < N stops reading early.
  task automatic run_frame(input string tag, input logic [N-1:0] cells, input int tlast_beat,
                           input int gens, input logic w, input bit rand_rdy, input int n_out);
    logic [N-1:0] g, gb;
    int           last_in, e0, e0b, lat, beats, t;
    bit           stalled, rdy;
    logic [31:0]  pd;
    logic         pl;
    beat_t        eb;

    last_in = (tlast_beat < 0) ? N - 1 : tlast_beat;
    g = cells;
    for (int k = 0; k < N; k++) if (k > last_in) g[k] = 1'b0;
    gb = g;
    for (int i = 0; i < gens; i++) begin
      g  = life_step(g,  w, B3,  S23);
      gb = life_step(gb, w, B36, S23);
    end
    for (int k = 0; k < N; k++) begin
      q_exp.push_back('{data: g[k] ? ALIVE : DEAD, last: (k == N - 1)});
      q_exp_b.push_back('{data: gb[k] ? ALIVE : DEAD, last: (k == N - 1)});
    end
    e0  = err_seen;
    e0b = err_seen_b;
    gen_count = 8'(gens);
    wrap      = w;

    for (int k = 0; k <= last_in; k++) begin
      @(negedge clk);
      if (k == 1) begin
        gen_count = ~gen_count;
        wrap      = ~wrap;
      end
      s_tvalid = 1'b1;
      s_tdata  = cells[k] ? ALIVE : ($urandom() & 32'hFFFF_FFFE);
      s_tlast  = (k == tlast_beat);
      t = 0;
      while (!s_tready && t < 100) begin
        @(negedge clk);
        t++;
      end
      check({tag, "_in_ready"}, 64'(s_tready), 64'd1);
      check({tag, "_in_ready_b36"}, 64'(s_tready_b), 64'd1);
      @(posedge clk);
    end

    @(negedge clk);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    lat = 1;
    while (!m_tvalid && lat < 2000) begin
      check({tag, "_held_off"}, 64'(s_tready), 64'd0);
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(1 + gens * H));
    check({tag, "_valid_b36"}, 64'(m_tvalid_b), 64'd1);

    beats = 0;
    t = 0;
    stalled = 1'b0;
    while (beats < n_out && t < 2000) begin
      if (stalled) begin
        check({tag, "_stall_valid"}, 64'(m_tvalid), 64'd1);
        check({tag, "_stall_data"}, 64'(m_tdata), 64'(pd));
        check({tag, "_stall_last"}, 64'(m_tlast), 64'(pl));
      end
      check({tag, "_s_ready_low"}, 64'(s_tready), 64'd0);
      check({tag, "_s_ready_low_b36"}, 64'(s_tready_b), 64'd0);
      rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      m_tready = rdy;
      if (m_tvalid && rdy) begin
        eb = (q_exp.size() > 0) ? q_exp.pop_front() : '{data: 32'hDEAD_BEEF, last: 1'bx};
        check($sformatf("%s_data[%0d]", tag, beats), 64'(m_tdata), 64'(eb.data));
        check($sformatf("%s_last[%0d]", tag, beats), 64'(m_tlast), 64'(eb.last));
        eb = (q_exp_b.size() > 0) ? q_exp_b.pop_front() : '{data: 32'hDEAD_BEEF, last: 1'bx};
        check($sformatf("%s_b36_valid[%0d]", tag, beats), 64'(m_tvalid_b), 64'd1);
        check($sformatf("%s_b36_data[%0d]", tag, beats), 64'(m_tdata_b), 64'(eb.data));
        check($sformatf("%s_b36_last[%0d]", tag, beats), 64'(m_tlast_b), 64'(eb.last));
        beats++;
        stalled = 1'b0;
      end else begin
        stalled = m_tvalid;
        pd = m_tdata;
        pl = m_tlast;
      end
      @(negedge clk);
      t++;
    end
    check({tag, "_beats"}, 64'(beats), 64'(n_out));

    if (n_out == N) begin
      m_tready = 1'b0;
      check({tag, "_done_valid"}, 64'(m_tvalid), 64'd0);
      check({tag, "_done_s_ready"}, 64'(s_tready), 64'd1);
    end
    check({tag, "_err_pulses"}, 64'(err_seen - e0), 64'(tlast_beat != N - 1));
    check({tag, "_err_pulses_b36"}, 64'(err_seen_b - e0b), 64'(tlast_beat != N - 1));
  endtask

  initial begin
    logic [N-1:0] rc;
    rst         = 1'b0;
    alive_color = ALIVE;
    dead_color  = DEAD;
    gen_count   = 8'd0;
    wrap        = 1'b0;
    s_tvalid    = 1'b0;
    s_tdata     = '0;
    s_tlast     = 1'b0;
    m_tready    = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_s_ready", 64'(s_tready), 64'd0);
    check("rst_m_valid", 64'(m_tvalid), 64'd0);
    check("rst_m_last",  64'(m_tlast),  64'd0);
    check("rst_err",     64'(err_tlast), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_release_s_ready", 64'(s_tready), 64'd1);

    run_frame("blink_nowrap", 16'h0007, 15, 1, 1'b0, 1'b0, N);
    run_frame("blink_wrap_g1", 16'h0007, 15, 1, 1'b1, 1'b0, N);
    run_frame("blink_wrap_g2", 16'h0007, 15, 2, 1'b1, 1'b0, N);
    run_frame("gen0_copy", 16'hA5C3, 15, 0, 1'b0, 1'b0, N);
    rc = 16'($urandom());
    run_frame("rand_ready", rc, 15, 3, 1'b1, 1'b1, N);
    run_frame("tlast_early", 16'hFFFF, 5, 0, 1'b0, 1'b0, N);
    run_frame("tlast_missing", 16'h0770, -1, 1, 1'b0, 1'b0, N);
    run_frame("b36_birth", 16'h0707, 15, 1, 1'b0, 1'b1, N);

    run_frame("rst_mid_send", 16'h0660, 15, 1, 1'b1, 1'b0, 7);
    rst      = 1'b0;
    m_tready = 1'b0;
    q_exp.delete();
    q_exp_b.delete();
    @(negedge clk);
    check("mid_rst_m_valid", 64'(m_tvalid), 64'd0);
    check("mid_rst_m_last",  64'(m_tlast),  64'd0);
    check("mid_rst_s_ready", 64'(s_tready), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_release_s_ready", 64'(s_tready), 64'd1);
    run_frame("after_rst", 16'h0007, 15, 1, 1'b0, 1'b1, N);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
